// File: rtl/pe_brick_sequencer.sv
// Issue-side driver for a 16-brick bit-fusion PE: splits 2/4-bit operand vectors into
// 2-bit brick beats, drives the PE and accumulates its registered products into one dot product.
module pe_brick_sequencer #(
    parameter int unsigned ACC_W = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_mode,
    input  logic [63:0]             i_act,
    input  logic [63:0]             i_wgt,
    input  logic                    i_a_signed,
    input  logic                    i_w_signed,
    output logic [31:0]             o_pe_activation,
    output logic [31:0]             o_pe_weight,
    output logic                    o_pe_A_signed,
    output logic                    o_pe_W_signed,
    output logic [3:0]              o_pe_shift_amount,
    input  logic signed [18:0]      i_pe_prod,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [ACC_W-1:0] o_sum
);

    localparam int unsigned VEC_W   = 64;
    localparam int unsigned BRK_W   = 32;
    localparam int unsigned SH_W    = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned N_BRICK = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [VEC_W-1:0]        act_q, wgt_q;
    logic                    mode_q, a_signed_q, w_signed_q;
    logic                    drv_vld_q, prod_vld_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    ready_q, valid_q;
    logic [BRK_W-1:0]        pe_act_q, pe_wgt_q;
    logic                    pe_as_q, pe_ws_q;
    logic [SH_W-1:0]         pe_shift_q;

    logic                    accept, issue;
    logic [CNT_W-1:0]        beats_total;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    assign beats_total = mode_q ? CNT_W'(4) : CNT_W'(1);

    // Next-state: beat 0 is loaded on the accept edge, remaining beats from ISSUE
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    issue   = 1'b1;
                    beat_d  = CNT_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (beat_q < beats_total) begin
                    issue  = 1'b1;
                    beat_d = beat_q + CNT_W'(1);
                end else begin
                    beat_d  = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (valid_q && i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [VEC_W-1:0] src_act, src_wgt;
    logic             src_mode, src_as, src_ws;
    logic [1:0]       beat_idx;
    logic [BRK_W-1:0] brk_act, brk_wgt;
    logic             brk_as, brk_ws;
    logic [SH_W-1:0]  brk_shift;
    logic [3:0]       a4, w4;

    // Beat builder: bit 0 of the beat index picks the activation half, bit 1 the weight half
    always_comb begin
        src_act   = accept ? i_act : act_q;
        src_wgt   = accept ? i_wgt : wgt_q;
        src_mode  = accept ? i_mode : mode_q;
        src_as    = accept ? i_a_signed : a_signed_q;
        src_ws    = accept ? i_w_signed : w_signed_q;
        beat_idx  = accept ? 2'd0 : beat_q[1:0];
        brk_act   = '0;
        brk_wgt   = '0;
        a4        = '0;
        w4        = '0;
        for (int k = 0; k < N_BRICK; k++) begin
            if (src_mode) begin
                a4 = src_act[4*k +: 4];
                w4 = src_wgt[4*k +: 4];
                brk_act[2*k +: 2] = beat_idx[0] ? a4[3:2] : a4[1:0];
                brk_wgt[2*k +: 2] = beat_idx[1] ? w4[3:2] : w4[1:0];
            end else begin
                brk_act[2*k +: 2] = src_act[2*k +: 2];
                brk_wgt[2*k +: 2] = src_wgt[2*k +: 2];
            end
        end
        if (src_mode) begin
            brk_as    = beat_idx[0] & src_as;
            brk_ws    = beat_idx[1] & src_ws;
            brk_shift = SH_W'({beat_idx[0] & beat_idx[1], beat_idx[0] ^ beat_idx[1], 1'b0});
        end else begin
            brk_as    = src_as;
            brk_ws    = src_ws;
            brk_shift = '0;
        end
    end

    // Request capture, PE drive, product pipeline tracking and accumulation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            act_q      <= '0;
            wgt_q      <= '0;
            mode_q     <= 1'b0;
            a_signed_q <= 1'b0;
            w_signed_q <= 1'b0;
            drv_vld_q  <= 1'b0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            pe_act_q   <= '0;
            pe_wgt_q   <= '0;
            pe_as_q    <= 1'b0;
            pe_ws_q    <= 1'b0;
            pe_shift_q <= '0;
        end else begin
            ready_q    <= (state_d == S_IDLE);
            valid_q    <= (state_d == S_DONE);
            drv_vld_q  <= issue;
            prod_vld_q <= drv_vld_q;
            if (accept) begin
                act_q      <= i_act;
                wgt_q      <= i_wgt;
                mode_q     <= i_mode;
                a_signed_q <= i_a_signed;
                w_signed_q <= i_w_signed;
            end
            if (issue) begin
                pe_act_q   <= brk_act;
                pe_wgt_q   <= brk_wgt;
                pe_as_q    <= brk_as;
                pe_ws_q    <= brk_ws;
                pe_shift_q <= brk_shift;
            end else begin
                pe_act_q   <= '0;
                pe_wgt_q   <= '0;
                pe_as_q    <= 1'b0;
                pe_ws_q    <= 1'b0;
                pe_shift_q <= '0;
            end
            if (accept) begin
                acc_q <= '0;
            end else if (prod_vld_q) begin
                acc_q <= acc_q + ACC_W'(i_pe_prod);
            end
        end
    end

    assign o_ready           = ready_q;
    assign o_valid           = valid_q;
    assign o_sum             = acc_q;
    assign o_pe_activation   = pe_act_q;
    assign o_pe_weight       = pe_wgt_q;
    assign o_pe_A_signed     = pe_as_q;
    assign o_pe_W_signed     = pe_ws_q;
    assign o_pe_shift_amount = pe_shift_q;

endmodule

// File: tb/tb_pe_brick_sequencer.sv
// Directed bench for pe_brick_sequencer with a behavioural 16-brick PE looped back on i_pe_prod.
module tb_pe_brick_sequencer;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic               o_ready;
    logic               i_mode;
    logic [63:0]        i_act;
    logic [63:0]        i_wgt;
    logic               i_a_signed;
    logic               i_w_signed;
    logic [31:0]        o_pe_activation;
    logic [31:0]        o_pe_weight;
    logic               o_pe_A_signed;
    logic               o_pe_W_signed;
    logic [3:0]         o_pe_shift_amount;
    logic signed [18:0] i_pe_prod;
    logic               o_valid;
    logic               i_ready;
    logic signed [19:0] o_sum;

    int pass_cnt = 0;
    int total_cnt = 0;

    pe_brick_sequencer #(.ACC_W(20)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_mode            (i_mode),
        .i_act             (i_act),
        .i_wgt             (i_wgt),
        .i_a_signed        (i_a_signed),
        .i_w_signed        (i_w_signed),
        .o_pe_activation   (o_pe_activation),
        .o_pe_weight       (o_pe_weight),
        .o_pe_A_signed     (o_pe_A_signed),
        .o_pe_W_signed     (o_pe_W_signed),
        .o_pe_shift_amount (o_pe_shift_amount),
        .i_pe_prod         (i_pe_prod),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_sum             (o_sum)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural PE: sum of 16 brick products, shifted, registered once
    function automatic logic signed [18:0] pe_model(input logic [31:0] a, input logic [31:0] w,
                                                    input logic as, input logic ws, input logic [3:0] sh);
        int s;
        int av;
        int wv;
        logic [1:0] ab;
        logic [1:0] wb;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            ab = a[2*k +: 2];
            wb = w[2*k +: 2];
            av = (as && ab[1]) ? int'(ab) - 4 : int'(ab);
            wv = (ws && wb[1]) ? int'(wb) - 4 : int'(wb);
            s += av * wv;
        end
        return 19'(s << sh);
    endfunction

    initial i_pe_prod = '0;
    always @(posedge i_clk)
        i_pe_prod <= pe_model(o_pe_activation, o_pe_weight, o_pe_A_signed, o_pe_W_signed, o_pe_shift_amount);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(negedge i_clk);
    endtask

    // Presents a request at a negedge where o_ready is high; returns at the negedge after acceptance
    task automatic start_req(input logic mode, input logic [63:0] act, input logic [63:0] wgt,
                             input logic sa, input logic sw);
        i_valid = 1'b1; i_mode = mode; i_act = act; i_wgt = wgt; i_a_signed = sa; i_w_signed = sw;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0; i_mode = ~mode; i_act = ~act; i_wgt = ~wgt; i_a_signed = ~sa; i_w_signed = ~sw;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) step();
        i_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            total_cnt++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== 20'sd0 || o_pe_activation !== 32'h0 ||
                o_pe_weight !== 32'h0 || o_pe_A_signed !== 1'b0 || o_pe_W_signed !== 1'b0 ||
                o_pe_shift_amount !== 4'd0)
                $display("FAIL reset_idle cyc%0d: rdy=%b vld=%b sum=%0d act=%h wgt=%h as=%b ws=%b sh=%0d (want 1 0 0 zeros)",
                         c, o_ready, o_valid, o_sum, o_pe_activation, o_pe_weight, o_pe_A_signed,
                         o_pe_W_signed, o_pe_shift_amount);
            else pass_cnt++;
        end
    endtask

    task automatic test_2bit();
        start_req(1'b0, {32'hA5A5A5A5, {16{2'b11}}}, {32'h5A5A5A5A, {16{2'b01}}}, 1'b1, 1'b1);
        total_cnt++;
        if (o_pe_activation !== 32'hFFFFFFFF || o_pe_weight !== 32'h55555555 ||
            {o_pe_A_signed, o_pe_W_signed, o_pe_shift_amount} !== 6'b11_0000)
            $display("FAIL 2b_beat: act=%h wgt=%h as=%b ws=%b sh=%0d (want ffffffff 55555555 1 1 0)",
                     o_pe_activation, o_pe_weight, o_pe_A_signed, o_pe_W_signed, o_pe_shift_amount);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_valid !== 1'b0 || o_pe_activation !== 32'h0 || o_pe_weight !== 32'h0 || o_pe_shift_amount !== 4'd0)
            $display("FAIL 2b_gap: vld=%b act=%h wgt=%h sh=%0d (want 0 zeros)",
                     o_valid, o_pe_activation, o_pe_weight, o_pe_shift_amount);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== -20'sd16 || o_ready !== 1'b0)
            $display("FAIL 2b_signed_sum: vld=%b sum=%0d rdy=%b (want 1 -16 0)", o_valid, o_sum, o_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1)
            $display("FAIL 2b_handshake: vld=%b rdy=%b (want 0 1)", o_valid, o_ready);
        else pass_cnt++;
        start_req(1'b0, {32'h0, {16{2'b11}}}, {32'h0, {16{2'b11}}}, 1'b0, 1'b0);
        repeat (2) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 20'sd144)
            $display("FAIL 2b_unsigned_sum: vld=%b sum=%0d (want 1 144)", o_valid, o_sum);
        else pass_cnt++;
        step();
    endtask

    task automatic test_4bit();
        logic [5:0]  exp_ctl [4];
        logic [31:0] exp_act [4];
        logic [31:0] exp_wgt [4];
        exp_ctl[0] = 6'b00_0000; exp_act[0] = 32'h0;        exp_wgt[0] = 32'h0;
        exp_ctl[1] = 6'b10_0010; exp_act[1] = 32'hAAAAAAAA; exp_wgt[1] = 32'h0;
        exp_ctl[2] = 6'b01_0010; exp_act[2] = 32'h0;        exp_wgt[2] = 32'hAAAAAAAA;
        exp_ctl[3] = 6'b11_0100; exp_act[3] = 32'hAAAAAAAA; exp_wgt[3] = 32'hAAAAAAAA;
        start_req(1'b1, {16{4'h8}}, {16{4'h8}}, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            total_cnt++;
            if ({o_pe_A_signed, o_pe_W_signed, o_pe_shift_amount} !== exp_ctl[b] ||
                o_pe_activation !== exp_act[b] || o_pe_weight !== exp_wgt[b])
                $display("FAIL 4b_beat%0d: as=%b ws=%b sh=%0d act=%h wgt=%h (want ctl=%b act=%h wgt=%h)",
                         b, o_pe_A_signed, o_pe_W_signed, o_pe_shift_amount, o_pe_activation,
                         o_pe_weight, exp_ctl[b], exp_act[b], exp_wgt[b]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (o_valid !== 1'b0 || o_pe_activation !== 32'h0 || o_pe_shift_amount !== 4'd0 || o_pe_A_signed !== 1'b0)
            $display("FAIL 4b_drain: vld=%b act=%h sh=%0d as=%b (want 0 0 0 0)",
                     o_valid, o_pe_activation, o_pe_shift_amount, o_pe_A_signed);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 20'sd1024)
            $display("FAIL 4b_signed_sum: vld=%b sum=%0d (want 1 1024)", o_valid, o_sum);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL 4b_handshake: rdy=%b vld=%b (want 1 0)", o_ready, o_valid);
        else pass_cnt++;
        start_req(1'b1, {16{4'hF}}, {16{4'hF}}, 1'b1, 1'b0);
        repeat (5) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== -20'sd240)
            $display("FAIL 4b_mixed_sum: vld=%b sum=%0d (want 1 -240)", o_valid, o_sum);
        else pass_cnt++;
        step();
        start_req(1'b1, {16{4'hF}}, {16{4'hF}}, 1'b0, 1'b0);
        repeat (5) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 20'sd3600)
            $display("FAIL 4b_unsigned_sum: vld=%b sum=%0d (want 1 3600)", o_valid, o_sum);
        else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        start_req(1'b0, {32'h0, {16{2'b01}}}, {32'h0, {16{2'b11}}}, 1'b0, 1'b0);
        repeat (2) step();
        i_valid = 1'b1; i_mode = 1'b0; i_a_signed = 1'b0; i_w_signed = 1'b0;
        i_act = {32'h0, {16{2'b10}}}; i_wgt = {32'h0, {16{2'b10}}};
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (o_valid !== 1'b1 || o_sum !== 20'sd48 || o_ready !== 1'b0)
                $display("FAIL bp_hold cyc%0d: vld=%b sum=%0d rdy=%b (want 1 48 0)", c, o_valid, o_sum, o_ready);
            else pass_cnt++;
            step();
        end
        i_ready = 1'b1;
        step();
        total_cnt++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1)
            $display("FAIL bp_release: vld=%b rdy=%b (want 0 1)", o_valid, o_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_ready !== 1'b0)
            $display("FAIL bp_next_accept: rdy=%b (want 0)", o_ready);
        else pass_cnt++;
        i_valid = 1'b0;
        repeat (2) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 20'sd64)
            $display("FAIL bp_next_sum: vld=%b sum=%0d (want 1 64)", o_valid, o_sum);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        i_valid = 1'b1; i_mode = 1'b0; i_a_signed = 1'b1; i_w_signed = 1'b1;
        i_act = {32'h0, {16{2'b01}}}; i_wgt = {32'h0, {16{2'b11}}};
        repeat (3) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== -20'sd16)
            $display("FAIL b2b_first: vld=%b sum=%0d (want 1 -16)", o_valid, o_sum);
        else pass_cnt++;
        i_a_signed = 1'b0; i_w_signed = 1'b0;
        i_act = {32'h0, {16{2'b11}}}; i_wgt = {32'h0, {16{2'b11}}};
        step();
        total_cnt++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL b2b_gap: rdy=%b vld=%b (want 1 0)", o_ready, o_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_ready !== 1'b0)
            $display("FAIL b2b_accept: rdy=%b (want 0)", o_ready);
        else pass_cnt++;
        i_valid = 1'b0;
        repeat (2) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 20'sd144)
            $display("FAIL b2b_second: vld=%b sum=%0d (want 1 144)", o_valid, o_sum);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_req(1'b1, {16{4'h7}}, {16{4'h7}}, 1'b0, 1'b0);
        repeat (2) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        total_cnt++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== 20'sd0 || o_pe_activation !== 32'h0 ||
            o_pe_weight !== 32'h0 || o_pe_shift_amount !== 4'd0 || o_pe_W_signed !== 1'b0)
            $display("FAIL midrst_state: rdy=%b vld=%b sum=%0d act=%h wgt=%h sh=%0d (want 1 0 0 zeros)",
                     o_ready, o_valid, o_sum, o_pe_activation, o_pe_weight, o_pe_shift_amount);
        else pass_cnt++;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen |= o_valid;
        end
        total_cnt++;
        if (seen !== 1'b0)
            $display("FAIL midrst_no_valid: saw o_valid=%b (want 0)", seen);
        else pass_cnt++;
        start_req(1'b0, {32'h0, {16{2'b01}}}, {32'h0, {16{2'b01}}}, 1'b1, 1'b1);
        repeat (2) step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 20'sd16)
            $display("FAIL midrst_next_sum: vld=%b sum=%0d (want 1 16)", o_valid, o_sum);
        else pass_cnt++;
        step();
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_act = '0; i_wgt = '0;
        i_a_signed = 1'b0; i_w_signed = 1'b0; i_ready = 1'b1;
        test_reset();
        test_2bit();
        test_4bit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
